// File: rtl/dq_format_decoder_pipe.sv
// dq_format_decoder_pipe: stage-1 DQ-form decoder (lq, lxv, stxv) with an
// output queue and a valid/ready handshake toward stage 2. Non-DQ words are
// consumed without pushing so sibling format decoders can claim them.
// Optional feature macro: DQ_ILLEGAL_TRAP_EN routes illegal lq forms to the
// trap unit with no register scoreboard action.
module dq_format_decoder_pipe #(
  parameter int unsigned opcodeWidth      = 6,
  parameter int unsigned regWidth         = 5,
  parameter int unsigned immWidth         = 16,
  parameter int unsigned instructionWidth = 32,
  parameter int unsigned queueDepth       = 2,
  parameter logic [1:0]  regImm           = 2'd0,
  parameter logic [1:0]  regRead          = 2'd1,
  parameter logic [1:0]  regWrite         = 2'd2,
  parameter logic [1:0]  regReadWrite     = 2'd3,
  parameter logic [2:0]  FXUnitCode       = 3'd0,
  parameter logic [2:0]  FPUnitCode       = 3'd1,
  parameter logic [2:0]  LdStUnitCode     = 3'd2,
  parameter logic [2:0]  BranchUnitCode   = 3'd3,
  parameter logic [2:0]  TrapUnitCode     = 3'd4
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic                        enable_i,
  input  logic [instructionWidth-1:0] instruction_i,
  output logic                        stall_o,
  input  logic                        ready_i,
  output logic                        enable_o,
  output logic [regWidth-1:0]         reg1_o,
  output logic [regWidth-1:0]         reg2_o,
  output logic [1:0]                  reg1Use_o,
  output logic [1:0]                  reg2Use_o,
  output logic [immWidth-1:0]         imm_o,
  output logic                        bit_o,
  output logic [1:0]                  opType_o,
  output logic                        illegal_o,
  output logic [2:0]                  functionalUnitCode_o
);

  localparam int unsigned PtrW = (queueDepth > 1) ? $clog2(queueDepth) : 1;
  localparam int unsigned CntW = $clog2(queueDepth + 1);
  localparam int unsigned Msb  = instructionWidth - 1;

  // Elaboration-time sanity check of the configuration.
  if (queueDepth < 2 || (queueDepth & (queueDepth - 1)) != 0 || immWidth < 16 ||
      regImm == regRead || regRead == regWrite || regWrite == regReadWrite ||
      FXUnitCode == FPUnitCode || FPUnitCode == LdStUnitCode ||
      LdStUnitCode == BranchUnitCode || BranchUnitCode == TrapUnitCode) begin : g_bad_cfg
    $error("dq_format_decoder_pipe: invalid parameter configuration");
  end

  typedef struct packed {
    logic [regWidth-1:0] reg1;
    logic [regWidth-1:0] reg2;
    logic [1:0]          reg1_use;
    logic [1:0]          reg2_use;
    logic [immWidth-1:0] imm;
    logic                ext_bit;
    logic [1:0]          op_type;
    logic                illegal;
    logic [2:0]          unit;
  } entry_t;

  // Instruction fields, big-endian bit numbering (bit 0 = MSB).
  logic [opcodeWidth-1:0] opcode;
  logic [regWidth-1:0]    rt;
  logic [regWidth-1:0]    ra;
  logic [15:0]            disp;
  logic [2:0]             xo;
  logic                   xbit;

  assign opcode = instruction_i[Msb -: opcodeWidth];
  assign rt     = instruction_i[Msb - 6 -: regWidth];
  assign ra     = instruction_i[Msb - 11 -: regWidth];
  assign disp   = {instruction_i[Msb - 16 -: 12], 4'b0000};
  assign xbit   = instruction_i[Msb - 28];
  assign xo     = instruction_i[Msb - 29 -: 3];

  entry_t dec;
  logic   is_dq;

  // Decode the fetched word into a queue entry.
  always_comb begin
    dec          = '0;
    is_dq        = 1'b0;
    dec.reg1     = rt;
    dec.reg2     = ra;
    dec.imm      = immWidth'($signed(disp));
    dec.unit     = LdStUnitCode;
    dec.reg2_use = regRead;
    if (opcode == opcodeWidth'(56)) begin
      is_dq        = 1'b1;
      dec.reg1_use = regWrite;
      dec.op_type  = 2'd0;
`ifdef DQ_ILLEGAL_TRAP_EN
      if (rt[0] || (rt == ra)) begin
        dec.illegal  = 1'b1;
        dec.unit     = TrapUnitCode;
        dec.reg1_use = regImm;
        dec.reg2_use = regImm;
      end
`endif
    end else if (opcode == opcodeWidth'(61) && xo == 3'd1) begin
      is_dq        = 1'b1;
      dec.reg1_use = regWrite;
      dec.ext_bit  = xbit;
      dec.op_type  = 2'd1;
    end else if (opcode == opcodeWidth'(61) && xo == 3'd5) begin
      is_dq        = 1'b1;
      dec.reg1_use = regRead;
      dec.ext_bit  = xbit;
      dec.op_type  = 2'd2;
    end
  end

  entry_t            mem [queueDepth];
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_next;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_next;
  logic              push;
  logic              pop;
  entry_t            head_next;

  assign stall_o = (count == CntW'(queueDepth));
  assign push    = enable_i && !stall_o && is_dq;
  assign pop     = enable_o && ready_i;

  // Next occupancy, read pointer and head entry (bypass when the new head is being pushed).
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CntW'(1);
    end else if (pop && !push) begin
      count_next = count - CntW'(1);
    end
    rd_next   = pop ? PtrW'(rd_ptr + PtrW'(1)) : rd_ptr;
    head_next = (push && rd_next == wr_ptr) ? dec : mem[rd_next];
  end

  // Circular buffer storage and pointers.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(queueDepth); i++) begin
        mem[i] <= '0;
      end
    end else begin
      rd_ptr <= rd_next;
      count  <= count_next;
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= PtrW'(wr_ptr + PtrW'(1));
      end
    end
  end

  // Registered head-entry outputs; fields hold when the queue drains.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      enable_o             <= 1'b0;
      reg1_o               <= '0;
      reg2_o               <= '0;
      reg1Use_o            <= '0;
      reg2Use_o            <= '0;
      imm_o                <= '0;
      bit_o                <= 1'b0;
      opType_o             <= '0;
      illegal_o            <= 1'b0;
      functionalUnitCode_o <= '0;
    end else begin
      enable_o <= (count_next != '0);
      if (count_next != '0) begin
        reg1_o               <= head_next.reg1;
        reg2_o               <= head_next.reg2;
        reg1Use_o            <= head_next.reg1_use;
        reg2Use_o            <= head_next.reg2_use;
        imm_o                <= head_next.imm;
        bit_o                <= head_next.ext_bit;
        opType_o             <= head_next.op_type;
        illegal_o            <= head_next.illegal;
        functionalUnitCode_o <= head_next.unit;
      end else begin
        functionalUnitCode_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dq_format_decoder_pipe.sv
// Self-checking bench for dq_format_decoder_pipe: decode vector table plus
// directed throughput, stall/backpressure and reset-flush sequences.
module tb_dq_format_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic [31:0] instruction_i = '0;
  logic        stall_o;
  logic        ready_i = 1'b1;
  logic        enable_o;
  logic [4:0]  reg1_o, reg2_o;
  logic [1:0]  reg1Use_o, reg2Use_o;
  logic [15:0] imm_o;
  logic        bit_o;
  logic [1:0]  opType_o;
  logic        illegal_o;
  logic [2:0]  functionalUnitCode_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dq_format_decoder_pipe dut (
    .clock_i(clk), .resetn_i(rst_n), .enable_i(enable_i), .instruction_i(instruction_i),
    .stall_o(stall_o), .ready_i(ready_i), .enable_o(enable_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg1Use_o(reg1Use_o), .reg2Use_o(reg2Use_o),
    .imm_o(imm_o), .bit_o(bit_o), .opType_o(opType_o), .illegal_o(illegal_o),
    .functionalUnitCode_o(functionalUnitCode_o)
  );

`ifdef DQ_ILLEGAL_TRAP_EN
  localparam logic       ILL_FLAG = 1'b1;
  localparam logic [2:0] ILL_UNIT = 3'd4;
  localparam logic [1:0] ILL_U1   = 2'd0;
  localparam logic [1:0] ILL_U2   = 2'd0;
`else
  localparam logic       ILL_FLAG = 1'b0;
  localparam logic [2:0] ILL_UNIT = 3'd2;
  localparam logic [1:0] ILL_U1   = 2'd2;
  localparam logic [1:0] ILL_U2   = 2'd1;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [1:0]  u1;
    logic [1:0]  u2;
    logic [15:0] imm;
    logic        b;
    logic [1:0]  op;
    logic        ill;
    logic [2:0]  unit;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic [31:0] instr, logic valid, logic [4:0] r1, logic [4:0] r2,
                              logic [1:0] u1, logic [1:0] u2, logic [15:0] imm, logic b,
                              logic [1:0] op, logic ill, logic [2:0] unit);
    vec_t v;
    v.instr = instr; v.valid = valid; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.imm = imm; v.b = b; v.op = op; v.ill = ill; v.unit = unit;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [31:0] W0 = 32'hE0830020; // lq rt=4 ra=3
  localparam logic [31:0] W1 = 32'hE0C30020; // lq rt=6 ra=3
  localparam logic [31:0] W2 = 32'hE1030020; // lq rt=8 ra=3

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'hE0830020, 1, 4, 3, 2, 1, 16'h0020, 0, 0, 0, 3'd2);
    vecs[1] = mk(32'hF422FFF9, 1, 1, 2, 2, 1, 16'hFFF0, 1, 1, 0, 3'd2);
    vecs[2] = mk(32'hF4220015, 1, 1, 2, 1, 1, 16'h0010, 0, 2, 0, 3'd2);
    vecs[3] = mk(32'hF422001D, 1, 1, 2, 1, 1, 16'h0010, 1, 2, 0, 3'd2);
    vecs[4] = mk(32'hE083FFF0, 1, 4, 3, 2, 1, 16'hFFF0, 0, 0, 0, 3'd2);
    vecs[5] = mk(32'hE0A30020, 1, 5, 3, ILL_U1, ILL_U2, 16'h0020, 0, 0, ILL_FLAG, ILL_UNIT);
    vecs[6] = mk(32'hE0840020, 1, 4, 4, ILL_U1, ILL_U2, 16'h0020, 0, 0, ILL_FLAG, ILL_UNIT);
    vecs[7] = mk(32'h7C000000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 3'd0);
    vecs[8] = mk(32'hF4220002, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 3'd0);

    // Reset state.
    #2;
    chk("rst_enable", 32'(enable_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_reg1", 32'(reg1_o), 0);
    chk("rst_imm", 32'(imm_o), 0);
    chk("rst_unit", 32'(functionalUnitCode_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table, one word at a time with ready held high.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      enable_i = 1'b1;
      instruction_i = vecs[i].instr;
      @(negedge clk);
      enable_i = 1'b0;
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_enable", i), 32'(enable_o), 1);
        chk($sformatf("v%0d_reg1", i), 32'(reg1_o), 32'(vecs[i].r1));
        chk($sformatf("v%0d_reg2", i), 32'(reg2_o), 32'(vecs[i].r2));
        chk($sformatf("v%0d_use1", i), 32'(reg1Use_o), 32'(vecs[i].u1));
        chk($sformatf("v%0d_use2", i), 32'(reg2Use_o), 32'(vecs[i].u2));
        chk($sformatf("v%0d_imm", i), 32'(imm_o), 32'(vecs[i].imm));
        chk($sformatf("v%0d_bit", i), 32'(bit_o), 32'(vecs[i].b));
        chk($sformatf("v%0d_optype", i), 32'(opType_o), 32'(vecs[i].op));
        chk($sformatf("v%0d_illegal", i), 32'(illegal_o), 32'(vecs[i].ill));
        chk($sformatf("v%0d_unit", i), 32'(functionalUnitCode_o), 32'(vecs[i].unit));
      end else begin
        chk($sformatf("v%0d_no_enable", i), 32'(enable_o), 0);
        chk($sformatf("v%0d_no_stall", i), 32'(stall_o), 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_enable", i), 32'(enable_o), 0);
      chk($sformatf("v%0d_idle_unit", i), 32'(functionalUnitCode_o), 0);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_hold_imm", i), 32'(imm_o), 32'(vecs[i].imm));
      end
    end

    // Back-to-back throughput with ready high.
    @(negedge clk); enable_i = 1'b1; instruction_i = W0;
    @(negedge clk); chk("tp_en0", 32'(enable_o), 1); chk("tp_reg1_0", 32'(reg1_o), 4); instruction_i = W1;
    @(negedge clk); chk("tp_en1", 32'(enable_o), 1); chk("tp_reg1_1", 32'(reg1_o), 6); instruction_i = W2;
    @(negedge clk); chk("tp_en2", 32'(enable_o), 1); chk("tp_reg1_2", 32'(reg1_o), 8); enable_i = 1'b0;
    @(negedge clk); chk("tp_drained", 32'(enable_o), 0);

    // Backpressure: fill, hold third word, then drain in order.
    ready_i = 1'b0;
    @(negedge clk); enable_i = 1'b1; instruction_i = W0;
    @(negedge clk); chk("bp_en", 32'(enable_o), 1); chk("bp_stall0", 32'(stall_o), 0); instruction_i = W1;
    @(negedge clk); chk("bp_stall_full", 32'(stall_o), 1); chk("bp_head0", 32'(reg1_o), 4); instruction_i = W2;
    @(negedge clk); chk("bp_stall_hold", 32'(stall_o), 1); chk("bp_head_hold", 32'(reg1_o), 4); ready_i = 1'b1;
    @(negedge clk); chk("bp_stall_fall", 32'(stall_o), 0); chk("bp_head1", 32'(reg1_o), 6); chk("bp_en1", 32'(enable_o), 1);
    @(negedge clk); chk("bp_head2", 32'(reg1_o), 8); chk("bp_en2", 32'(enable_o), 1); enable_i = 1'b0;
    @(negedge clk); chk("bp_empty", 32'(enable_o), 0); chk("bp_empty_stall", 32'(stall_o), 0);

    // Reset flush with two entries queued.
    ready_i = 1'b0;
    @(negedge clk); enable_i = 1'b1; instruction_i = W0;
    @(negedge clk); instruction_i = W1;
    @(negedge clk); enable_i = 1'b0; chk("fl_full", 32'(stall_o), 1);
    rst_n = 1'b0;
    #1;
    chk("fl_enable", 32'(enable_o), 0);
    chk("fl_stall", 32'(stall_o), 0);
    chk("fl_reg1", 32'(reg1_o), 0);
    chk("fl_unit", 32'(functionalUnitCode_o), 0);
    @(negedge clk); rst_n = 1'b1; ready_i = 1'b1;
    @(negedge clk); enable_i = 1'b1; instruction_i = W1;
    @(negedge clk); enable_i = 1'b0;
    chk("fl_post_en", 32'(enable_o), 1);
    chk("fl_post_reg1", 32'(reg1_o), 6);
    chk("fl_post_reg2", 32'(reg2_o), 3);
    chk("fl_post_imm", 32'(imm_o), 32'h20);
    @(negedge clk); chk("fl_post_empty", 32'(enable_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
